filesize_transfer_scheduler: RTL and testbench

Round-robin scheduler that shares one file-transfer datapath among NREQ requesters. Each granted request supplies a file size (in words) and a base address. The block counts out exactly that many address beats on a valid/ready stream, then signals completion back to the owner. It sits between the request sources and the address-calculation datapath, and replaces free-running per-source filesize counting with one arbitrated, back-pressurable sequencer.

---
 rtl/filesize_transfer_scheduler.sv | 126 ++++++++++++
 tb/tb_filesize_transfer_scheduler.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filesize_transfer_scheduler.sv
// Round-robin transfer sequencer: grants one requester at a time, streams
// base..base+size-1 on a valid/ready address port, then pulses done.
module filesize_transfer_scheduler #(
  parameter int NREQ = 4,
  parameter int IDW  = 2,
  parameter int SW   = 32,
  parameter int AW   = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req,
  input  logic [NREQ*SW-1:0] req_size,
  input  logic [NREQ*AW-1:0] req_base,
  output logic [NREQ-1:0]    ack,
  output logic [NREQ-1:0]    done,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [AW-1:0]      out_addr,
  output logic               out_last,
  output logic               busy,
  output logic [IDW-1:0]     grant_id
);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

  state_t         state, state_nx;
  logic [IDW-1:0] rr_ptr, gsel;
  logic           gfound;
  logic [SW-1:0]  sel_size, size_p0, count_p0, count_nx;
  logic [AW-1:0]  sel_base, base_p0;
  logic           beat_fire;

  assign beat_fire = out_valid & out_ready;
  assign count_nx  = count_p0 + SW'(1);

  // Winner is the requesting index with the smallest circular distance past rr_ptr.
  always_comb begin
    int best, d;
    gfound   = 1'b0;
    gsel     = '0;
    sel_size = '0;
    sel_base = '0;
    best     = NREQ;
    d        = 0;
    for (int i = 0; i < NREQ; i++) begin
      d = i - int'(rr_ptr) - 1;
      if (d < 0) d = d + NREQ;
      if (req[i] && d < best) begin
        best     = d;
        gfound   = 1'b1;
        gsel     = IDW'(i);
        sel_size = req_size[i*SW +: SW];
        sel_base = req_base[i*AW +: AW];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (gfound) state_nx = (sel_size != '0) ? RUN : FIN;
      RUN:     if (beat_fire && out_last) state_nx = FIN;
      FIN:     state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Grant-time capture of the winner's descriptor
  always_ff @(posedge clk) begin
    if (state == IDLE && gfound) begin
      size_p0 <= sel_size;
      base_p0 <= sel_base;
    end
  end

  // Registered control and beat outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack       <= '0;
      done      <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_addr  <= '0;
      busy      <= 1'b0;
      grant_id  <= '0;
      rr_ptr    <= IDW'(NREQ-1);
      count_p0  <= '0;
    end else begin
      ack  <= '0;
      done <= '0;
      case (state)
        IDLE: if (gfound) begin
          ack[gsel] <= 1'b1;
          grant_id  <= gsel;
          busy      <= 1'b1;
          count_p0  <= '0;
          out_valid <= (sel_size != '0);
          out_addr  <= sel_base;
          out_last  <= (sel_size == SW'(1));
        end
        RUN: if (beat_fire) begin
          if (out_last) begin
            out_valid      <= 1'b0;
            out_last       <= 1'b0;
            done[grant_id] <= 1'b1;
          end else begin
            count_p0 <= count_nx;
            out_addr <= base_p0 + AW'(count_nx);
            out_last <= (count_nx == size_p0 - SW'(1));
          end
        end
        FIN: begin
          rr_ptr <= grant_id;
          busy   <= 1'b0;
          // A zero-size grant has no last beat, so its done lands one cycle after ack.
          if (size_p0 == '0) done[grant_id] <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_filesize_transfer_scheduler.sv
// Self-checking bench for filesize_transfer_scheduler: directed scenarios plus
// randomized traffic against a queue-free round-robin/beat reference model.
module tb_filesize_transfer_scheduler;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int SW   = 32;
  localparam int AW   = 32;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [NREQ-1:0]    req = '0;
  logic [NREQ*SW-1:0] req_size = '0;
  logic [NREQ*AW-1:0] req_base = '0;
  logic [NREQ-1:0]    ack, done;
  logic               out_valid, out_last, busy;
  logic               out_ready = 1'b0;
  logic [AW-1:0]      out_addr;
  logic [IDW-1:0]     grant_id;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;

  filesize_transfer_scheduler #(.NREQ(NREQ), .IDW(IDW), .SW(SW), .AW(AW)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_size(req_size), .req_base(req_base),
    .ack(ack), .done(done), .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_last(out_last), .busy(busy), .grant_id(grant_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_req(input int i, input logic [SW-1:0] s, input logic [AW-1:0] b);
    req_size[i*SW +: SW] = s;
    req_base[i*AW +: AW] = b;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
  endtask

  // Reference arbitration: first set bit searching circularly from ptr+1.
  function automatic int pick(input logic [NREQ-1:0] r, input int ptr);
    for (int k = 1; k <= NREQ; k++) begin
      int idx;
      idx = (ptr + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [NREQ-1:0] onehot(input int i);
    logic [NREQ-1:0] one;
    one = 1;
    return one << i;
  endfunction

  task automatic test_reset();
    logic [2*NREQ+AW+3+IDW-1:0] outs;
    rst_n = 1'b0;
    req = '0;
    out_ready = 1'b0;
    repeat (3) tick();
    outs = {ack, done, out_valid, out_last, out_addr, busy, grant_id};
    total++;
    if (outs !== '0) $display("FAIL reset_held: outputs=%h expected 0", outs);
    else passed++;
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      outs = {ack, done, out_valid, out_last, out_addr, busy, grant_id};
      total++;
      if (outs !== '0) $display("FAIL reset_idle cycle %0d: outputs=%h expected 0", i, outs);
      else passed++;
    end
  endtask

  task automatic test_single();
    logic [AW-1:0] ea;
    set_req(1, 3, 32'h100);
    out_ready = 1'b1;
    req = 4'b0010;
    tick();
    total++;
    if ({ack, grant_id, busy} !== {4'b0010, 2'd1, 1'b1})
      $display("FAIL single_ack: ack=%b grant_id=%0d busy=%b expected 0010/1/1", ack, grant_id, busy);
    else passed++;
    req = '0;
    for (int k = 0; k < 3; k++) begin
      ea = 32'h100 + AW'(k);
      total++;
      if ({out_valid, out_last, out_addr} !== {1'b1, (k == 2), ea} || (k > 0 && ack !== '0))
        $display("FAIL single_beat %0d: valid=%b last=%b addr=%h ack=%b expected 1/%0d/%h", k,
                 out_valid, out_last, out_addr, ack, (k == 2), ea);
      else passed++;
      tick();
    end
    total++;
    if ({done, out_valid, busy} !== {4'b0010, 1'b0, 1'b1})
      $display("FAIL single_done: done=%b valid=%b busy=%b expected 0010/0/1", done, out_valid, busy);
    else passed++;
    tick();
    total++;
    if ({done, busy, grant_id} !== {4'b0000, 1'b0, 2'd1})
      $display("FAIL single_idle: done=%b busy=%b grant_id=%0d expected 0000/0/1", done, busy, grant_id);
    else passed++;
  endtask

  task automatic test_round_robin();
    int ptr, got, last_cyc, exp_id;
    apply_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, 1, AW'(32'h1000 * (i + 1)));
    req = '1;
    out_ready = 1'b1;
    ptr = NREQ - 1;
    got = 0;
    last_cyc = 0;
    for (int c = 0; c < 40 && got < 5; c++) begin
      tick();
      if (ack != '0) begin
        exp_id = pick(req, ptr);
        total++;
        if (ack !== onehot(exp_id) || grant_id !== IDW'(exp_id))
          $display("FAIL rr_order grant %0d: ack=%b grant_id=%0d expected id %0d", got, ack, grant_id, exp_id);
        else passed++;
        if (got > 0) begin
          total++;
          if (cyc - last_cyc != 3) $display("FAIL rr_spacing grant %0d: gap=%0d expected 3", got, cyc - last_cyc);
          else passed++;
        end
        last_cyc = cyc;
        ptr = exp_id;
        got++;
      end
    end
    total++;
    if (got != 5) $display("FAIL rr_count: grants=%0d expected 5", got);
    else passed++;
    req = '0;
    repeat (6) tick();
  endtask

  task automatic test_backpressure_wrap();
    int hs, p;
    logic seen_done, prev_stall, pl;
    logic [AW-1:0] pa, ea;
    set_req(0, 3, 32'hFFFF_FFFE);
    req = 4'b0001;
    out_ready = 1'b0;
    tick();
    total++;
    if (ack !== 4'b0001) $display("FAIL bp_ack: ack=%b expected 0001", ack);
    else passed++;
    req = '0;
    hs = 0; p = 0; seen_done = 1'b0; prev_stall = 1'b0; pa = '0; pl = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (done != '0) begin
        seen_done = 1'b1;
        total++;
        if (done !== 4'b0001 || out_valid !== 1'b0)
          $display("FAIL bp_done: done=%b valid=%b expected 0001/0", done, out_valid);
        else passed++;
      end else begin
        if (prev_stall) begin
          total++;
          if ({out_valid, out_last, out_addr} !== {1'b1, pl, pa})
            $display("FAIL bp_stable: valid=%b last=%b addr=%h expected 1/%b/%h", out_valid, out_last, out_addr, pl, pa);
          else passed++;
        end
        out_ready = (p % 3 == 0);
        p++;
        if (out_valid && out_ready) begin
          ea = 32'hFFFF_FFFE + AW'(hs);
          total++;
          if (out_addr !== ea || out_last !== (hs == 2))
            $display("FAIL bp_beat %0d: addr=%h last=%b expected %h/%0d", hs, out_addr, out_last, ea, (hs == 2));
          else passed++;
          hs++;
          prev_stall = 1'b0;
        end else begin
          prev_stall = out_valid;
          pa = out_addr;
          pl = out_last;
        end
        tick();
      end
    end
    total++;
    if (!seen_done || hs != 3) $display("FAIL bp_handshakes: count=%0d done_seen=%b expected 3/1", hs, seen_done);
    else passed++;
    out_ready = 1'b1;
    repeat (2) tick();
  endtask

  task automatic test_zero_size();
    logic bad;
    set_req(2, 0, 32'h5555);
    req = 4'b0100;
    tick();
    total++;
    if (ack !== 4'b0100 || out_valid !== 1'b0 || busy !== 1'b1)
      $display("FAIL zero_ack: ack=%b valid=%b busy=%b expected 0100/0/1", ack, out_valid, busy);
    else passed++;
    req = '0;
    tick();
    total++;
    if (done !== 4'b0100 || ack !== '0 || out_valid !== 1'b0)
      $display("FAIL zero_done: done=%b ack=%b valid=%b expected 0100/0000/0", done, ack, out_valid);
    else passed++;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (out_valid !== 1'b0 || done !== '0 || busy !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL zero_quiet: valid/done/busy active=%b expected 0", bad);
    else passed++;
  endtask

  task automatic test_reset_mid();
    int beats;
    logic bad;
    logic [2*NREQ+AW+3+IDW-1:0] outs;
    set_req(0, 10, 32'h2000);
    req = 4'b0001;
    out_ready = 1'b1;
    tick();
    total++;
    if (ack !== 4'b0001) $display("FAIL rstmid_ack: ack=%b expected 0001", ack);
    else passed++;
    req = '0;
    beats = 0;
    for (int c = 0; c < 20 && beats < 4; c++) begin
      if (out_valid && out_ready) beats++;
      tick();
    end
    rst_n = 1'b0;
    tick();
    outs = {ack, done, out_valid, out_last, out_addr, busy, grant_id};
    total++;
    if (beats != 4 || outs !== '0) $display("FAIL rstmid_clear: beats=%0d outputs=%h expected 4/0", beats, outs);
    else passed++;
    rst_n = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (done !== '0 || out_valid !== 1'b0) bad = 1'b1;
    end
    total++;
    if (bad) $display("FAIL rstmid_nodone: stray done/valid=%b expected 0", bad);
    else passed++;
    set_req(3, 2, 32'h3000);
    req = 4'b1000;
    tick();
    total++;
    if ({ack, grant_id, out_valid, out_last, out_addr} !== {4'b1000, 2'd3, 1'b1, 1'b0, 32'h3000})
      $display("FAIL rstmid_regrant: ack=%b id=%0d valid=%b last=%b addr=%h expected 1000/3/1/0/3000",
               ack, grant_id, out_valid, out_last, out_addr);
    else passed++;
    req = '0;
    tick();
    total++;
    if ({out_valid, out_last, out_addr} !== {1'b1, 1'b1, 32'h3001})
      $display("FAIL rstmid_beat2: valid=%b last=%b addr=%h expected 1/1/3001", out_valid, out_last, out_addr);
    else passed++;
    tick();
    total++;
    if (done !== 4'b1000) $display("FAIL rstmid_done: done=%b expected 1000", done);
    else passed++;
    repeat (2) tick();
  endtask

  task automatic test_random();
    logic [SW-1:0]   rs[NREQ];
    logic [AW-1:0]   rb[NREQ];
    logic [NREQ-1:0] req_prev;
    logic [AW-1:0]   ea;
    int ptr, cur_id, k, completed, exp_id;
    logic active;
    apply_reset();
    ptr = NREQ - 1;
    active = 1'b0;
    cur_id = 0;
    k = 0;
    completed = 0;
    req_prev = '0;
    for (int i = 0; i < NREQ; i++) begin
      rs[i] = '0;
      rb[i] = '0;
    end
    for (int c = 0; c < 4000 && completed < 40; c++) begin
      tick();
      if (done != '0) begin
        total++;
        if (!active || done !== onehot(cur_id) || k != int'(rs[cur_id]))
          $display("FAIL rand_done: done=%b beats=%0d expected id %0d after %0d beats", done, k, cur_id, rs[cur_id]);
        else passed++;
        active = 1'b0;
        completed++;
      end
      if (ack != '0) begin
        exp_id = pick(req_prev, ptr);
        total++;
        if (active || exp_id < 0 || ack !== onehot(exp_id) || grant_id !== IDW'(exp_id))
          $display("FAIL rand_grant: ack=%b grant_id=%0d req=%b expected id %0d", ack, grant_id, req_prev, exp_id);
        else passed++;
        if (exp_id >= 0) begin
          active = 1'b1;
          cur_id = exp_id;
          ptr = exp_id;
          k = 0;
          req[exp_id] = 1'b0;
        end
      end
      out_ready = ($urandom_range(0, 9) < 7);
      if (out_valid && out_ready) begin
        ea = rb[cur_id] + AW'(k);
        total++;
        if (!active || k >= int'(rs[cur_id]) || out_addr !== ea || out_last !== (k == int'(rs[cur_id]) - 1))
          $display("FAIL rand_beat %0d: addr=%h last=%b expected %h last=%0d", k, out_addr, out_last, ea,
                   (k == int'(rs[cur_id]) - 1));
        else passed++;
        k++;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i] && !(active && cur_id == i) && $urandom_range(0, 3) == 0) begin
          rs[i] = SW'($urandom_range(0, 5));
          rb[i] = AW'($urandom);
          set_req(i, rs[i], rb[i]);
          req[i] = 1'b1;
        end
      end
      req_prev = req;
    end
    total++;
    if (completed < 40) $display("FAIL rand_progress: completed=%0d expected 40", completed);
    else passed++;
    req = '0;
    out_ready = 1'b1;
    repeat (10) tick();
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_backpressure_wrap();
    test_zero_size();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
